// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the staged reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    DONE    = 2'd2,
    ASSERT  = 2'd3
  } state_t;

  localparam int DEF_GAP_CYCLES     = 16;
  localparam int DEF_SW_HOLD_CYCLES = 8;

  // Wide enough to hold the larger of the two terminal counts without wrapping.
  function automatic int cnt_width(input int gap, input int hold);
    int m;
    m = (gap > hold) ? gap : hold;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/reset_seq_gap_counter.sv
// Free-running edge counter with a terminal-count pulse; clears itself at tc.
module reset_seq_gap_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic [W-1:0] tc_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  assign tc = (cnt == tc_val);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         cnt <= '0;
    else if (clear || tc) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release with software-reset replay.
// Optional: RESET_SEQ_REVERSE_ASSERT_EN drops stages high-to-low on software reset.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES     = 4,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int SW_HOLD_CYCLES = DEF_SW_HOLD_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sw_rst_req,
  output logic                  sw_rst_ack,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  all_released,
  output logic                  busy
);

  localparam int CW = cnt_width(GAP_CYCLES, SW_HOLD_CYCLES);
  localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [CW-1:0] GAP_TC  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_TC = CW'(SW_HOLD_CYCLES - 1);
  localparam logic [IW-1:0] LAST    = IW'(NUM_STAGES - 1);

  state_t        state;
  logic [IW-1:0] idx;
  logic          dropping;
  logic          tc;
  logic          cnt_clear;
  logic [CW-1:0] tc_val;

  // Counter is parked at zero in DONE so the software hold starts from a clean count.
  assign cnt_clear = (state == DONE);
  assign tc_val    = (state == ASSERT && !dropping) ? HOLD_TC : GAP_TC;

  reset_seq_gap_counter #(.W(CW)) u_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (cnt_clear),
    .tc_val (tc_val),
    .tc     (tc)
  );

`ifndef RESET_SEQ_REVERSE_ASSERT_EN
  assign dropping = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= HOLD;
      idx          <= '0;
      stage_rst_n  <= '0;
      all_released <= 1'b0;
      busy         <= 1'b1;
      sw_rst_ack   <= 1'b0;
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
      dropping     <= 1'b0;
`endif
    end else begin
      sw_rst_ack <= 1'b0;
      case (state)
        HOLD, RELEASE: if (tc) begin
          stage_rst_n[idx] <= 1'b1;
          if (idx == LAST) begin
            state        <= DONE;
            all_released <= 1'b1;
            busy         <= 1'b0;
          end else begin
            idx   <= idx + 1'b1;
            state <= RELEASE;
          end
        end
        DONE: if (sw_rst_req) begin
          state        <= ASSERT;
          all_released <= 1'b0;
          busy         <= 1'b1;
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
          // Thermometer code: a right shift drops the highest released stage.
          stage_rst_n  <= stage_rst_n >> 1;
          dropping     <= |(stage_rst_n >> 1);
`else
          stage_rst_n  <= '0;
`endif
        end
        ASSERT: if (tc) begin
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
          if (dropping) begin
            stage_rst_n <= stage_rst_n >> 1;
            dropping    <= |(stage_rst_n >> 1);
          end else begin
            sw_rst_ack <= 1'b1;
            state      <= HOLD;
            idx        <= '0;
          end
`else
          sw_rst_ack <= 1'b1;
          state      <= HOLD;
          idx        <= '0;
`endif
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench: power-on schedule, software reset, async mid-sequence reset, request while sequencing.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic       sw_req1 = 1'b0;
  logic       sw_rst_ack, all_released, busy;
  logic [3:0] stage_rst_n;
  logic       ack1, all1, busy1;
  logic [0:0] stage1;

  int tests = 0;
  int fails = 0;
  int ecnt  = 0;

`ifdef RESET_SEQ_REVERSE_ASSERT_EN
  localparam int SW_ACK_E  = 156;
  localparam int REQ_ACK_E = 121;
`else
  localparam int SW_ACK_E  = 108;
  localparam int REQ_ACK_E = 73;
`endif

  always #5 clk = ~clk;

  reset_sequencer #(.NUM_STAGES(4), .GAP_CYCLES(16), .SW_HOLD_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n), .sw_rst_req(sw_rst_req), .sw_rst_ack(sw_rst_ack),
    .stage_rst_n(stage_rst_n), .all_released(all_released), .busy(busy)
  );

  reset_sequencer #(.NUM_STAGES(1), .GAP_CYCLES(1), .SW_HOLD_CYCLES(8)) dut_min (
    .clk(clk), .reset_n(reset_n), .sw_rst_req(sw_req1), .sw_rst_ack(ack1),
    .stage_rst_n(stage1), .all_released(all1), .busy(busy1)
  );

  // Advance to just after edge e (edge 1 = first edge sampling reset_n high).
  task automatic go_to(input int e);
    while (ecnt < e) begin
      @(posedge clk);
      ecnt++;
    end
    #1;
  endtask

  task automatic release_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    ecnt = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    tests++;
    if (stage_rst_n !== 4'b0000 || all_released !== 1'b0 || busy !== 1'b1 || sw_rst_ack !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: stage=%b all=%b busy=%b ack=%b want 0000/0/1/0",
               stage_rst_n, all_released, busy, sw_rst_ack);
    end
    tests++;
    if (stage1 !== 1'b0 || all1 !== 1'b0 || busy1 !== 1'b1) begin
      fails++;
      $display("FAIL reset_state_min: stage=%b all=%b busy=%b want 0/0/1", stage1, all1, busy1);
    end
    reset_n = 1'b1;
    ecnt = 0;
  endtask

  task automatic test_power_on();
    int edges [8] = '{15, 16, 31, 32, 47, 48, 63, 64};
    int stg   [8] = '{0, 1, 1, 3, 3, 7, 7, 15};
    logic [3:0] want;
    go_to(1);
    tests++;
    if (stage1 !== 1'b1 || all1 !== 1'b1 || busy1 !== 1'b0) begin
      fails++;
      $display("FAIL min_cfg_edge1: stage=%b all=%b busy=%b want 1/1/0", stage1, all1, busy1);
    end
    for (int i = 0; i < 8; i++) begin
      go_to(edges[i]);
      want = stg[i][3:0];
      tests++;
      if (stage_rst_n !== want || all_released !== (want == 4'hf) || busy !== (want != 4'hf)) begin
        fails++;
        $display("FAIL power_on@%0d: stage=%b all=%b busy=%b want stage=%b", edges[i],
                 stage_rst_n, all_released, busy, want);
      end
    end
  endtask

  task automatic test_sw_reset();
    int exp;
    go_to(99);
    sw_rst_req = 1'b1;
    go_to(100);
    sw_rst_req = 1'b0;
    tests++;
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
    if (stage_rst_n !== 4'b0111 || busy !== 1'b1 || all_released !== 1'b0) begin
`else
    if (stage_rst_n !== 4'b0000 || busy !== 1'b1 || all_released !== 1'b0) begin
`endif
      fails++;
      $display("FAIL sw_reset@100: stage=%b busy=%b all=%b", stage_rst_n, busy, all_released);
    end
    for (int e = 101; e <= 175; e++) begin
      go_to(e);
      tests++;
      if (sw_rst_ack !== (e == SW_ACK_E)) begin
        fails++;
        $display("FAIL sw_ack@%0d: ack=%b want %b", e, sw_rst_ack, (e == SW_ACK_E));
      end
      exp = -1;
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
      case (e)
        115: exp = 7;  116: exp = 3;  132: exp = 1;  147: exp = 1;
        148: exp = 0;  171: exp = 0;  172: exp = 1;
        default: exp = -1;
      endcase
`else
      case (e)
        107: exp = 0;  123: exp = 0;  124: exp = 1;  171: exp = 7;
        172: exp = 15;
        default: exp = -1;
      endcase
`endif
      if (exp >= 0) begin
        tests++;
        if (stage_rst_n !== exp[3:0]) begin
          fails++;
          $display("FAIL sw_stage@%0d: stage=%b want %b", e, stage_rst_n, exp[3:0]);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    reset_n = 1'b0;
    release_reset();
    go_to(40);
    tests++;
    if (stage_rst_n !== 4'b0011) begin
      fails++;
      $display("FAIL mid_pre@40: stage=%b want 0011", stage_rst_n);
    end
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if (stage_rst_n !== 4'b0000 || all_released !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_async: stage=%b all=%b busy=%b want 0000/0/1", stage_rst_n, all_released, busy);
    end
    release_reset();
    go_to(15);
    tests++;
    if (stage_rst_n !== 4'b0000) begin
      fails++;
      $display("FAIL mid_restart@15: stage=%b want 0000", stage_rst_n);
    end
    go_to(16);
    tests++;
    if (stage_rst_n !== 4'b0001) begin
      fails++;
      $display("FAIL mid_restart@16: stage=%b want 0001", stage_rst_n);
    end
  endtask

  task automatic test_req_while_seq();
    go_to(19);
    sw_rst_req = 1'b1;
    for (int e = 20; e <= 64; e++) begin
      go_to(e);
      tests++;
      if (sw_rst_ack !== 1'b0) begin
        fails++;
        $display("FAIL req_seq_ack@%0d: ack=%b want 0", e, sw_rst_ack);
      end
    end
    tests++;
    if (stage_rst_n !== 4'b1111 || all_released !== 1'b1) begin
      fails++;
      $display("FAIL req_seq@64: stage=%b all=%b want 1111/1", stage_rst_n, all_released);
    end
    go_to(65);
    sw_rst_req = 1'b0;
    tests++;
    if (stage_rst_n[3] !== 1'b0 || all_released !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL req_seq@65: stage=%b all=%b busy=%b want bit3=0/0/1", stage_rst_n, all_released, busy);
    end
    for (int e = 66; e <= 125; e++) begin
      go_to(e);
      tests++;
      if (sw_rst_ack !== (e == REQ_ACK_E)) begin
        fails++;
        $display("FAIL req_seq_ack@%0d: ack=%b want %b", e, sw_rst_ack, (e == REQ_ACK_E));
      end
    end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_sw_reset();
    test_mid_reset();
    test_req_while_seq();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
